muldiv_unit: RTL

Iterative RV32M multiply/divide execution unit. It consumes the 5-bit ALU_CONTROL code produced by alu_control_unit for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and returns a 32-bit result over a start/valid handshake. It sits in EX beside the single-cycle ALU. The pipeline stalls while BUSY is high.

---
 rtl/alu_ops_pkg.sv | 23 ++
 rtl/muldiv_sign_fix.sv | 16 +
 rtl/muldiv_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/alu_ops_pkg.sv
// alu_ops_pkg: ALU_CONTROL codes shared by the decoder, ALU and muldiv unit,
// plus the muldiv FSM states and opcode classifiers.
package alu_ops_pkg;
  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_MUL    = 5'b10000;
  localparam logic [4:0] ALU_MULH   = 5'b10001;
  localparam logic [4:0] ALU_MULHSU = 5'b10010;
  localparam logic [4:0] ALU_MULHU  = 5'b10011;
  localparam logic [4:0] ALU_DIV    = 5'b10100;
  localparam logic [4:0] ALU_DIVU   = 5'b10101;
  localparam logic [4:0] ALU_REM    = 5'b10110;
  localparam logic [4:0] ALU_REMU   = 5'b10111;
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX, ST_DONE} md_state_e;
  function automatic logic is_muldiv(input logic [4:0] op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction
  function automatic logic is_div_op(input logic [4:0] op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction
  function automatic logic is_rem_op(input logic [4:0] op);
    return op inside {ALU_REM, ALU_REMU};
  endfunction
endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: optional two's-complement negate of a double-width value,
// then high/low half select.
module muldiv_sign_fix #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] val_i,
  input  logic              neg_i,
  input  logic              sel_hi_i,
  output logic [XLEN-1:0]   res_o
);
  logic [2*XLEN-1:0] fixed;
  always_comb begin
    fixed = neg_i ? -val_i : val_i;
    res_o = sel_hi_i ? fixed[2*XLEN-1:XLEN] : fixed[XLEN-1:0];
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide; shift-add multiply and
// restoring divide on magnitudes, sign fixed up in a final cycle.
module muldiv_unit
  import alu_ops_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = XLEN
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            START,
  input  logic [4:0]      ALU_CONTROL,
  input  logic [XLEN-1:0] OPERAND1,
  input  logic [XLEN-1:0] OPERAND2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            VALID,
  output logic [XLEN-1:0] RESULT
);
  localparam int CW = $clog2(ITER + 1);
  md_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN:0]     hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d, b_q, b_d, result_q, result_d;
  logic [4:0]        op_q, op_d;
  logic              s1_q, s1_d, s2_q, s2_d;
  logic              sgn1, sgn2, div_zero, div_ovf, fast, fix_neg, fix_hi;
  logic [XLEN-1:0]   mag1, mag2, fix_res, fast_res;
  logic [XLEN:0]     step_sum, shifted, diff;
  logic [2*XLEN-1:0] fix_val;
  assign sgn1 = OPERAND1[XLEN-1] && (ALU_CONTROL inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
  assign sgn2 = OPERAND2[XLEN-1] && (ALU_CONTROL inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM});
  assign div_zero = OPERAND2 == '0;
  assign div_ovf = (ALU_CONTROL inside {ALU_DIV, ALU_REM}) && OPERAND1 == {1'b1, {(XLEN-1){1'b0}}} && OPERAND2 == '1;
  assign fast = is_div_op(ALU_CONTROL) && (div_zero || div_ovf);
  assign fast_res = div_zero ? (is_rem_op(ALU_CONTROL) ? OPERAND1 : '1) : (is_rem_op(ALU_CONTROL) ? '0 : OPERAND1);
  muldiv_sign_fix #(.XLEN(XLEN)) u_mag1 (.val_i({{XLEN{1'b0}}, OPERAND1}), .neg_i(sgn1), .sel_hi_i(1'b0), .res_o(mag1));
  muldiv_sign_fix #(.XLEN(XLEN)) u_mag2 (.val_i({{XLEN{1'b0}}, OPERAND2}), .neg_i(sgn2), .sel_hi_i(1'b0), .res_o(mag2));
  // hi_q holds the running upper product, or the remainder with its guard bit
  assign step_sum = hi_q + (lo_q[0] ? {1'b0, b_q} : '0);
  assign shifted = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
  assign diff = shifted - {1'b0, b_q};
  assign fix_val = is_rem_op(op_q) ? {{XLEN{1'b0}}, hi_q[XLEN-1:0]} :
                   is_div_op(op_q) ? {{XLEN{1'b0}}, lo_q} : {hi_q[XLEN-1:0], lo_q};
  assign fix_neg = is_rem_op(op_q) ? s1_q : s1_q ^ s2_q;
  assign fix_hi = !is_div_op(op_q) && op_q != ALU_MUL;
  muldiv_sign_fix #(.XLEN(XLEN)) u_fix (.val_i(fix_val), .neg_i(fix_neg), .sel_hi_i(fix_hi), .res_o(fix_res));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    b_d = b_q;
    op_d = op_q;
    s1_d = s1_q;
    s2_d = s2_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: if (START && !FLUSH && is_muldiv(ALU_CONTROL)) begin
        op_d = ALU_CONTROL;
        s1_d = sgn1;
        s2_d = sgn2;
        hi_d = '0;
        lo_d = mag1;
        b_d = mag2;
        cnt_d = CW'(ITER - 1);
        state_d = fast ? ST_DONE : ST_CALC;
        result_d = fast ? fast_res : result_q;
      end
      ST_CALC: begin
        hi_d = is_div_op(op_q) ? (diff[XLEN] ? shifted : diff) : {1'b0, step_sum[XLEN:1]};
        lo_d = is_div_op(op_q) ? {lo_q[XLEN-2:0], !diff[XLEN]} : {step_sum[0], lo_q[XLEN-1:1]};
        cnt_d = cnt_q - 1'b1;
        state_d = FLUSH ? ST_IDLE : (cnt_q == '0 ? ST_FIX : ST_CALC);
      end
      ST_FIX: begin
        state_d = FLUSH ? ST_IDLE : ST_DONE;
        result_d = FLUSH ? result_q : fix_res;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      b_q <= '0;
      op_q <= '0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      b_q <= b_d;
      op_q <= op_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      result_q <= result_d;
    end
  end
  assign BUSY = state_q inside {ST_CALC, ST_FIX};
  assign VALID = state_q == ST_DONE;
  assign RESULT = result_q;
endmodule
